// File: rtl/gpu_frame_sched.sv
// Per-frame GPU op scheduler: one clear op, then a round-robin merge of requester op
// lists into the GPU op FIFO, a drain wait, and a one-cycle swap pulse.
module gpu_frame_sched #(
    parameter int N_SRC       = 2,
    parameter int OP_WIDTH    = 32,
    parameter int IDLE_CYCLES = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i_frame_start,
    input  logic [OP_WIDTH-1:0]       i_clear_op,
    input  logic [N_SRC-1:0]          i_src_valid,
    input  logic [N_SRC*OP_WIDTH-1:0] i_src_op,
    input  logic [N_SRC-1:0]          i_src_last,
    output logic [N_SRC-1:0]          o_src_ready,
    input  logic                      i_fifo_full,
    input  logic                      i_fifo_empty,
    input  logic                      i_gpu_busy,
    output logic                      o_fifo_wr_en,
    output logic [OP_WIDTH-1:0]       o_fifo_din,
    output logic                      o_swap,
    output logic                      o_busy,
    output logic [7:0]                o_overrun_cnt
);
    localparam int RR_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    typedef enum logic [2:0] {IDLE, CLEAR, ARB, DRAIN, SWAP} state_t;

    state_t           r_state, w_state_nxt;
    logic [RR_W-1:0]  r_rr, w_rr_nxt;
    logic [N_SRC-1:0] r_done, w_done_nxt;
    logic [3:0]       r_idle_cnt, w_idle_nxt;
    logic             r_swap, r_busy;
    logic [7:0]       r_ovr;
    logic [N_SRC-1:0] w_elig;
    logic             w_gnt_vld;
    logic [RR_W-1:0]  w_gnt;

    assign w_elig = i_src_valid & ~r_done;

    // Scan offsets from the far end so the smallest offset from r_rr wins.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt     = '0;
        for (int k = N_SRC - 1; k >= 0; k--) begin
            for (int i = 0; i < N_SRC; i++) begin
                if (w_elig[i] && i == (int'(r_rr) + k) % N_SRC) begin
                    w_gnt_vld = 1'b1;
                    w_gnt     = RR_W'(i);
                end
            end
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_rr_nxt     = r_rr;
        w_done_nxt   = r_done;
        w_idle_nxt   = r_idle_cnt;
        o_src_ready  = '0;
        o_fifo_wr_en = 1'b0;
        o_fifo_din   = '0;
        case (r_state)
            IDLE: begin
                if (i_frame_start) begin
                    w_state_nxt = CLEAR;
                    w_done_nxt  = '0;
                end
            end
            CLEAR: begin
                if (!i_fifo_full) begin
                    o_fifo_wr_en = 1'b1;
                    o_fifo_din   = i_clear_op;
                    w_state_nxt  = ARB;
                end
            end
            ARB: begin
                if (!i_fifo_full && w_gnt_vld) begin
                    o_fifo_wr_en = 1'b1;
                    for (int i = 0; i < N_SRC; i++) begin
                        if (w_gnt == RR_W'(i)) begin
                            o_src_ready[i] = 1'b1;
                            o_fifo_din     = i_src_op[i*OP_WIDTH +: OP_WIDTH];
                            if (i_src_last[i]) w_done_nxt[i] = 1'b1;
                        end
                    end
                    w_rr_nxt = (w_gnt == RR_W'(N_SRC - 1)) ? '0 : RR_W'(w_gnt + 1'b1);
                    // The final accept and the move to DRAIN share this cycle.
                    if (&w_done_nxt) begin
                        w_state_nxt = DRAIN;
                        w_idle_nxt  = '0;
                    end
                end
            end
            DRAIN: begin
                if (i_fifo_empty && !i_gpu_busy) begin
                    w_idle_nxt = r_idle_cnt + 4'd1;
                    if (w_idle_nxt == 4'(IDLE_CYCLES)) w_state_nxt = SWAP;
                end else begin
                    w_idle_nxt = '0;
                end
            end
            SWAP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_rr       <= '0;
            r_done     <= '0;
            r_idle_cnt <= '0;
            r_swap     <= 1'b0;
            r_busy     <= 1'b0;
            r_ovr      <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_rr       <= w_rr_nxt;
            r_done     <= w_done_nxt;
            r_idle_cnt <= w_idle_nxt;
            r_swap     <= (w_state_nxt == SWAP);
            r_busy     <= (w_state_nxt != IDLE);
            if (i_frame_start && r_state != IDLE && r_ovr != 8'hFF) r_ovr <= r_ovr + 8'd1;
        end
    end

    assign o_swap        = r_swap;
    assign o_busy        = r_busy;
    assign o_overrun_cnt = r_ovr;
endmodule

// File: doc/gpu_frame_sched.md
# gpu_frame_sched

Per-frame command scheduler in front of the GPU op FIFO. On each frame-start pulse it pushes a fixed clear op, then merges the op lists of `N_SRC` requesters into the FIFO with round-robin arbitration. It then waits until the GPU has fully drained and pulses `swap` so the display side can flip framebuffers. It sits between the game/HUD logic (requesters) and the write port of the FIFO that feeds `gpu`.

## Interface
- `N_SRC`, default 2: number of requesters, 1..8.
- `OP_WIDTH`, default `$bits(gpu_op_t)`: width of one packed op.
- `IDLE_CYCLES`, default 4: consecutive idle cycles that define "GPU drained", 1..15.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `frame_start`  in  1  one-cycle pulse, e.g. vsync.
- `clear_op`  in  OP_WIDTH  background op, held stable by the owner.
- `src_valid`  in  N_SRC  requester i has an op on its lane.
- `src_op`  in  N_SRC*OP_WIDTH  lane i occupies bits [i*OP_WIDTH +: OP_WIDTH].
- `src_last`  in  N_SRC  the current op is the requester's final op this frame.
- `src_ready`  out  N_SRC  combinational grant; the op is accepted on `src_valid[i] && src_ready[i]`.
- `fifo_full`  in  1  GPU op FIFO full.
- `fifo_empty`  in  1  GPU op FIFO empty.
- `gpu_busy`  in  1  `gpu` `status_led` (GPU in WORK).
- `fifo_wr_en`  out  1  combinational FIFO write strobe.
- `fifo_din`  out  OP_WIDTH  combinational FIFO write data.
- `swap`  out  1  registered one-cycle pulse: frame complete.
- `busy`  out  1  registered; high whenever state != IDLE.
- `overrun_cnt`  out  8  registered, saturating count of dropped `frame_start` pulses.

## Operation
State machine: IDLE, CLEAR, ARB, DRAIN, SWAP.

- **IDLE:** `frame_start` → CLEAR. On entry, clear the done mask and keep the rr pointer.
- **CLEAR:** if `!fifo_full`, `fifo_wr_en=1`, `fifo_din=clear_op` → ARB. Otherwise stall in CLEAR.
- **ARB:**
  - Eligible requesters are `src_valid[i] && !done[i]`.
  - Grant the first eligible index at or after the rr pointer, cyclically.
  - When `!fifo_full`, `src_ready` is one-hot on the granted lane, `fifo_wr_en=1` and `fifo_din` = that lane's op. At most one op per cycle.
  - On accept, the rr pointer moves to granted+1 (mod `N_SRC`).
  - If `src_last` is set on accept, set `done[i]`.
  - When all done bits are set → DRAIN. The last accept and the transition share the cycle.
  - A requester with nothing to draw sends one op with width=0 and `src_last=1`; `gpu` discards it.
- **DRAIN:**
  - An idle counter increments while `fifo_empty && !gpu_busy`, and resets to 0 otherwise.
  - Reaching `IDLE_CYCLES` → SWAP.
  - The idle window covers the `gpu` fetch states and its 2-cycle write pipeline lag.
- **SWAP:** `swap=1` for one cycle → IDLE.
- **Outputs outside CLEAR/ARB:** `src_ready=0`, `fifo_wr_en=0`, `fifo_din=0`.
- **Frame overrun:** `frame_start` in any state except IDLE increments `overrun_cnt` (saturates at 255) and is otherwise ignored. A `frame_start` arriving in SWAP counts as an overrun.
- **Requester lane stability:** once `src_valid` is raised, op and last must hold until accepted. The scheduler never accepts on a deasserted lane.

## Timing
- **Reset (async, `rst_n=0`):**
  - State IDLE, rr pointer 0, done mask 0, idle counter 0.
  - `swap=0`, `busy=0`, `overrun_cnt=0`.
  - `src_ready`, `fifo_wr_en` and `fifo_din` are 0 (IDLE decode).
  - Reset mid-frame abandons the frame. The FIFO is not flushed; FIFO and `gpu` are reset by their owner.
- **Latency:**
  - `frame_start` in cycle t → clear op written in cycle t+1 if not full.
  - First requester op no earlier than t+2.
  - Full throughput: one op per cycle while `!fifo_full`.
  - `swap` no earlier than `IDLE_CYCLES`+1 cycles after the last accept.
- **Backpressure:** `fifo_full` is sampled combinationally. A write never occurs in a full cycle, and no accept occurs then.
- **Simultaneous events:**
  - `frame_start` together with the SWAP cycle counts as an overrun.
  - Last-op accept and `fifo_full` rising in the next cycle is harmless; state is already DRAIN.
- **Width rules:** the rr pointer is `$clog2(N_SRC)` bits (min 1) and wraps modulo `N_SRC`. The idle counter is 4 bits.

## Test plan
- **Basic frame** (`N_SRC`=2): src0 sends 3 ops (last on the 3rd), src1 sends 2 ops, FIFO never full. Required FIFO write order: clear, s0a, s1a, s0b, s1b, s0c. Then `swap` one cycle after 4 idle cycles.
- **Backpressure:** hold `fifo_full=1` for 5 cycles in CLEAR and for 3 cycles mid-ARB. Required: no writes and no `src_ready` in those cycles; the op sequence is unchanged.
- **Empty requester:** src1 sends a single width=0 op with last=1. Required: it is written exactly once, src0 then gets every grant, and the frame completes.
- **Drain gating:** after the last accept, toggle `gpu_busy` high for 1 cycle every 3 cycles for 20 cycles. Required: no `swap` until 4 consecutive idle cycles follow.
- **Overrun:** pulse `frame_start` 300 times during ARB/DRAIN. Required: `overrun_cnt` saturates at 255 and the frame sequence is undisturbed.
- **Async reset mid-ARB:** assert `rst_n=0` between clock edges. Required: `busy`, `src_ready` and `fifo_wr_en` drop to 0 immediately. After release, a new `frame_start` produces the clear op first, with the rr pointer starting at src0.
